// File: rtl/wrf_frame_gen.sv
// Pipelined WR-fabric frame source: MAC header, incrementing-byte payload and an
// optional OOB block, streamed as 16-bit beats with stall, ack accounting and abort.
module wrf_frame_gen #(
    parameter int unsigned g_max_len  = 1500,
    parameter logic [3:0]  g_oob_type = 4'h2
) (
    input  logic        clk_sys_i,
    input  logic        rst_n_i,
    input  logic        start_i,
    input  logic [15:0] len_i,
    input  logic [7:0]  seed_i,
    input  logic [47:0] dst_mac_i,
    input  logic [47:0] src_mac_i,
    input  logic [15:0] ethertype_i,
    input  logic        oob_en_i,
    input  logic [15:0] oob_frame_id_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o,
    output logic [31:0] frames_sent_o,
    output logic [15:0] src_dat_o,
    output logic [1:0]  src_adr_o,
    output logic [1:0]  src_sel_o,
    output logic        src_cyc_o,
    output logic        src_stb_o,
    output logic        src_we_o,
    input  logic        src_stall_i,
    input  logic        src_ack_i,
    input  logic        src_err_i,
    output logic [2:0]  dbg_state_o
);

    // Handshake: a beat transfers on every cycle with src_stb_o=1 and src_stall_i=0;
    // each transferred beat is owed one src_ack_i, and src_err_i aborts the frame.
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_HEADER   = 3'd1,
        S_PAYLOAD  = 3'd2,
        S_OOB      = 3'd3,
        S_WAIT_ACK = 3'd4
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] idx, idx_nxt;
    logic [10:0] cnt, cnt_nxt;
    logic        load, done_nxt, error_nxt;
    logic        accept, ack_eff, too_long;

    logic [15:0] len_q, etype_q, fid_q;
    logic [7:0]  seed_q;
    logic [47:0] dst_q, src_q;
    logic        oob_en_q;

    logic [16:0] two_j;
    logic [7:0]  b0, b1;
    logic        pl_last, lo_absent;

    assign src_cyc_o   = (state != S_IDLE);
    assign src_stb_o   = (state == S_HEADER) || (state == S_PAYLOAD) || (state == S_OOB);
    assign src_we_o    = 1'b1;
    assign busy_o      = src_cyc_o;
    assign dbg_state_o = state;

    assign accept   = src_stb_o && !src_stall_i;
    assign ack_eff  = src_cyc_o && src_ack_i && (cnt != 11'd0);
    assign too_long = (len_i > 16'(g_max_len));

    // Payload word j carries bytes 2j and 2j+1; the last word may hold only one byte.
    assign two_j     = {idx, 1'b0};
    assign b0        = seed_q + two_j[7:0];
    assign b1        = b0 + 8'd1;
    assign pl_last   = (two_j + 17'd2) >= {1'b0, len_q};
    assign lo_absent = (two_j + 17'd1) >= {1'b0, len_q};

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt + 11'(accept) - 11'(ack_eff);
        load      = 1'b0;
        done_nxt  = 1'b0;
        error_nxt = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_i) begin
                    if (too_long) begin
                        error_nxt = 1'b1;
                    end else begin
                        load      = 1'b1;
                        idx_nxt   = 16'd0;
                        state_nxt = S_HEADER;
                    end
                end
            end
            S_HEADER: begin
                if (accept) begin
                    if (idx == 16'd6) begin
                        idx_nxt = 16'd0;
                        if (len_q != 16'd0) state_nxt = S_PAYLOAD;
                        else if (oob_en_q)  state_nxt = S_OOB;
                        else                state_nxt = S_WAIT_ACK;
                    end else begin
                        idx_nxt = idx + 16'd1;
                    end
                end
            end
            S_PAYLOAD: begin
                if (accept) begin
                    if (pl_last) begin
                        idx_nxt   = 16'd0;
                        state_nxt = oob_en_q ? S_OOB : S_WAIT_ACK;
                    end else begin
                        idx_nxt = idx + 16'd1;
                    end
                end
            end
            S_OOB: begin
                if (accept) begin
                    if (idx == 16'd1) begin
                        idx_nxt   = 16'd0;
                        state_nxt = S_WAIT_ACK;
                    end else begin
                        idx_nxt = idx + 16'd1;
                    end
                end
            end
            S_WAIT_ACK: begin
                if (cnt_nxt == 11'd0) begin
                    state_nxt = S_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        // Sink error wins over everything else, including a completing WAIT_ACK.
        if (src_cyc_o && src_err_i) begin
            state_nxt = S_IDLE;
            idx_nxt   = 16'd0;
            cnt_nxt   = 11'd0;
            done_nxt  = 1'b0;
            error_nxt = 1'b1;
        end
    end

    always_comb begin
        src_dat_o = 16'h0000;
        src_adr_o = 2'b00;
        src_sel_o = 2'b11;
        case (state)
            S_HEADER: begin
                case (idx[2:0])
                    3'd0:    src_dat_o = dst_q[47:32];
                    3'd1:    src_dat_o = dst_q[31:16];
                    3'd2:    src_dat_o = dst_q[15:0];
                    3'd3:    src_dat_o = src_q[47:32];
                    3'd4:    src_dat_o = src_q[31:16];
                    3'd5:    src_dat_o = src_q[15:0];
                    3'd6:    src_dat_o = etype_q;
                    default: src_dat_o = 16'h0000;
                endcase
            end
            S_PAYLOAD: begin
                if (lo_absent) begin
                    src_dat_o = {b0, 8'h00};
                    src_sel_o = 2'b10;
                end else begin
                    src_dat_o = {b0, b1};
                end
            end
            S_OOB: begin
                src_adr_o = 2'b01;
                src_dat_o = idx[0] ? fid_q : {g_oob_type, 12'h000};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state         <= S_IDLE;
            idx           <= 16'd0;
            cnt           <= 11'd0;
            done_o        <= 1'b0;
            error_o       <= 1'b0;
            frames_sent_o <= 32'd0;
            len_q         <= 16'd0;
            seed_q        <= 8'd0;
            dst_q         <= 48'd0;
            src_q         <= 48'd0;
            etype_q       <= 16'd0;
            oob_en_q      <= 1'b0;
            fid_q         <= 16'd0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            cnt     <= cnt_nxt;
            done_o  <= done_nxt;
            error_o <= error_nxt;
            if (done_nxt) frames_sent_o <= frames_sent_o + 32'd1;
            if (load) begin
                len_q    <= len_i;
                seed_q   <= seed_i;
                dst_q    <= dst_mac_i;
                src_q    <= src_mac_i;
                etype_q  <= ethertype_i;
                oob_en_q <= oob_en_i;
                fid_q    <= oob_frame_id_i;
            end
        end
    end

endmodule

// File: tb/tb_wrf_frame_gen.sv
// Bench for wrf_frame_gen: sink model (stall/ack/err), beat scoreboard and
// directed frame scenarios with a single summary line.
module tb_wrf_frame_gen;

    logic        clk_sys_i = 1'b0;
    logic        rst_n_i;
    logic        start_i;
    logic [15:0] len_i;
    logic [7:0]  seed_i;
    logic [47:0] dst_mac_i;
    logic [47:0] src_mac_i;
    logic [15:0] ethertype_i;
    logic        oob_en_i;
    logic [15:0] oob_frame_id_i;
    logic        busy_o, done_o, error_o;
    logic [31:0] frames_sent_o;
    logic [15:0] src_dat_o;
    logic [1:0]  src_adr_o, src_sel_o;
    logic        src_cyc_o, src_stb_o, src_we_o;
    logic        src_stall_i, src_ack_i, src_err_i;
    logic [2:0]  dbg_state_o;

    wrf_frame_gen dut (
        .clk_sys_i(clk_sys_i), .rst_n_i(rst_n_i), .start_i(start_i), .len_i(len_i),
        .seed_i(seed_i), .dst_mac_i(dst_mac_i), .src_mac_i(src_mac_i),
        .ethertype_i(ethertype_i), .oob_en_i(oob_en_i), .oob_frame_id_i(oob_frame_id_i),
        .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .frames_sent_o(frames_sent_o),
        .src_dat_o(src_dat_o), .src_adr_o(src_adr_o), .src_sel_o(src_sel_o),
        .src_cyc_o(src_cyc_o), .src_stb_o(src_stb_o), .src_we_o(src_we_o),
        .src_stall_i(src_stall_i), .src_ack_i(src_ack_i), .src_err_i(src_err_i),
        .dbg_state_o(dbg_state_o)
    );

    always #5 clk_sys_i = ~clk_sys_i;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected beats, packed as {adr, sel, dat}.
    logic [19:0] exp_q[$];

    int cyc_cycles = 0, done_cnt = 0, err_cnt = 0, beats = 0;
    logic acc_flag = 1'b0;

    logic stall_mode = 1'b0, hold_acks = 1'b0, release_acks = 1'b0, err_mode = 1'b0;
    int   acc_total = 0, stall_ctr = 0, pending = 0;
    logic [1:0] ack_line = 2'b00;
    logic err_fired = 1'b0;

    localparam logic [47:0] DST = 48'h0050_C2AA_BB01;
    localparam logic [47:0] SRC = 48'h0050_C2CC_DD02;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_sys_i);
        #1;
    endtask

    task automatic push_frame(input int len, input logic [7:0] seed, input logic [15:0] et,
                              input logic oob, input logic [15:0] fid);
        logic [7:0] hi, lo;
        exp_q.push_back({4'b0011, DST[47:32]});
        exp_q.push_back({4'b0011, DST[31:16]});
        exp_q.push_back({4'b0011, DST[15:0]});
        exp_q.push_back({4'b0011, SRC[47:32]});
        exp_q.push_back({4'b0011, SRC[31:16]});
        exp_q.push_back({4'b0011, SRC[15:0]});
        exp_q.push_back({4'b0011, et});
        for (int k = 0; k < len; k += 2) begin
            hi = seed + 8'(k);
            lo = seed + 8'(k + 1);
            if (k + 1 < len) exp_q.push_back({4'b0011, hi, lo});
            else             exp_q.push_back({4'b0010, hi, 8'h00});
        end
        if (oob) begin
            exp_q.push_back({4'b0111, 16'h2000});
            exp_q.push_back({4'b0111, fid});
        end
    endtask

    task automatic start_frame(input int len, input logic [7:0] seed, input logic [15:0] et,
                               input logic oob, input logic [15:0] fid);
        len_i = 16'(len); seed_i = seed; ethertype_i = et; oob_en_i = oob; oob_frame_id_i = fid;
        dst_mac_i = DST; src_mac_i = SRC;
        if (len <= 1500) push_frame(len, seed, et, oob, fid);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0, n;
        d0 = done_cnt;
        n = 0;
        while (done_cnt == d0 && n < budget) begin
            tick();
            n++;
        end
        chk("done_seen", 32'(done_cnt != d0), 32'd1);
    endtask

    // Monitor: checks each presented beat against the scoreboard head.
    always @(negedge clk_sys_i) begin
        logic [19:0] got;
        acc_flag = 1'b0;
        if (rst_n_i && src_stb_o) begin
            got = {src_adr_o, src_sel_o, src_dat_o};
            if (exp_q.size() == 0) begin
                chk("extra_beat", {12'h0, got}, 32'hFFFF_FFFF);
            end else if (!src_stall_i) begin
                chk("beat", {12'h0, got}, {12'h0, exp_q.pop_front()});
                beats++;
                acc_flag = 1'b1;
            end else begin
                chk("held", {12'h0, got}, {12'h0, exp_q[0]});
            end
        end
        if (src_cyc_o) cyc_cycles++;
        if (done_o) begin
            done_cnt++;
            chk("done_cyc_low", 32'(src_cyc_o), 32'd0);
        end
        if (error_o) err_cnt++;
    end

    // Sink: acks arrive one full cycle after the accepting edge unless held back.
    initial begin
        src_stall_i = 1'b0; src_ack_i = 1'b0; src_err_i = 1'b0;
        forever begin
            @(posedge clk_sys_i);
            #1;
            if (!src_cyc_o) begin
                acc_total = 0; stall_ctr = 0; pending = 0; ack_line = 2'b00; err_fired = 1'b0;
                src_ack_i = 1'b0; src_stall_i = 1'b0; src_err_i = 1'b0;
            end else begin
                if (acc_flag) begin
                    acc_total++;
                    stall_ctr = 0;
                end
                if (hold_acks) begin
                    if (acc_flag) pending++;
                    if (release_acks && pending > 0) begin
                        src_ack_i = 1'b1;
                        pending--;
                    end else begin
                        src_ack_i = 1'b0;
                    end
                end else begin
                    ack_line  = {ack_line[0], acc_flag};
                    src_ack_i = ack_line[1];
                end
                src_stall_i = 1'b0;
                if (stall_mode && src_stb_o && acc_total >= 1 && acc_total <= 3 && stall_ctr < 3) begin
                    src_stall_i = 1'b1;
                    stall_ctr++;
                end
                src_err_i = 1'b0;
                if (err_mode && !err_fired && src_stb_o && acc_total == 7) begin
                    src_err_i = 1'b1;
                    err_fired = 1'b1;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, e0, d0, b0, n;
        rst_n_i = 1'b0; start_i = 1'b0; len_i = 16'd0; seed_i = 8'd0; dst_mac_i = 48'd0;
        src_mac_i = 48'd0; ethertype_i = 16'd0; oob_en_i = 1'b0; oob_frame_id_i = 16'd0;
        repeat (3) tick();
        chk("rst_cyc", 32'(src_cyc_o), 0);
        chk("rst_stb", 32'(src_stb_o), 0);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_done", 32'(done_o), 0);
        chk("rst_err", 32'(error_o), 0);
        chk("rst_dat", 32'(src_dat_o), 0);
        chk("rst_adr", 32'(src_adr_o), 0);
        chk("rst_sel", 32'(src_sel_o), 3);
        chk("rst_we", 32'(src_we_o), 1);
        chk("rst_frames", frames_sent_o, 0);
        chk("rst_state", 32'(dbg_state_o), 0);
        rst_n_i = 1'b1;
        tick();

        // Basic frame
        cyc_cycles = 0;
        start_frame(4, 8'h10, 16'h88F7, 1'b0, 16'h0);
        wait_done(100);
        chk("s1_frames", frames_sent_o, 1);
        chk("s1_cyc_cycles", 32'(cyc_cycles), 11);
        chk("s1_q_empty", 32'(exp_q.size()), 0);
        chk("s1_busy", 32'(busy_o), 0);

        // Odd length with OOB
        cyc_cycles = 0;
        start_frame(3, 8'hFE, 16'h88F7, 1'b1, 16'h0042);
        wait_done(100);
        chk("s2_frames", frames_sent_o, 2);
        chk("s2_cyc_cycles", 32'(cyc_cycles), 13);
        chk("s2_q_empty", 32'(exp_q.size()), 0);

        // Stall on beats 2-4
        stall_mode = 1'b1;
        cyc_cycles = 0;
        start_frame(4, 8'h10, 16'h88F7, 1'b0, 16'h0);
        wait_done(100);
        stall_mode = 1'b0;
        chk("s3_frames", frames_sent_o, 3);
        chk("s3_cyc_cycles", 32'(cyc_cycles), 20);
        chk("s3_q_empty", 32'(exp_q.size()), 0);

        // Delayed acks
        hold_acks = 1'b1;
        d0 = done_cnt;
        start_frame(4, 8'h10, 16'h88F7, 1'b0, 16'h0);
        n = 0;
        while (pending < 9 && n < 100) begin
            tick();
            n++;
        end
        chk("s4_pending", 32'(pending), 9);
        repeat (3) tick();
        chk("s4_wait_cyc", 32'(src_cyc_o), 1);
        chk("s4_wait_stb", 32'(src_stb_o), 0);
        chk("s4_wait_busy", 32'(busy_o), 1);
        chk("s4_no_done", 32'(done_cnt), 32'(d0));
        c0 = cyc_cycles;
        release_acks = 1'b1;
        wait_done(50);
        chk("s4_ack_cycles", 32'(cyc_cycles - c0), 9);
        chk("s4_frames", frames_sent_o, 4);
        release_acks = 1'b0;
        hold_acks = 1'b0;
        tick();

        // Abort on payload beat 1
        err_mode = 1'b1;
        e0 = err_cnt;
        start_frame(6, 8'h20, 16'h0800, 1'b0, 16'h0);
        n = 0;
        while (err_cnt == e0 && n < 50) begin
            tick();
            n++;
        end
        chk("s5_err_seen", 32'(err_cnt), 32'(e0 + 1));
        chk("s5_cyc_low", 32'(src_cyc_o), 0);
        chk("s5_stb_low", 32'(src_stb_o), 0);
        chk("s5_frames", frames_sent_o, 4);
        chk("s5_beats_left", 32'(exp_q.size()), 2);
        tick();
        chk("s5_err_pulse", 32'(error_o), 0);
        err_mode = 1'b0;
        exp_q.delete();
        repeat (2) tick();

        // Oversize reject
        e0 = err_cnt;
        cyc_cycles = 0;
        start_frame(1501, 8'h00, 16'h0800, 1'b0, 16'h0);
        repeat (5) tick();
        chk("s5_rej_err", 32'(err_cnt), 32'(e0 + 1));
        chk("s5_rej_cyc", 32'(cyc_cycles), 0);
        chk("s5_rej_frames", frames_sent_o, 4);

        // Zero length, header only
        cyc_cycles = 0;
        b0 = beats;
        start_frame(0, 8'h00, 16'h1234, 1'b0, 16'h0);
        wait_done(100);
        chk("s6_beats", 32'(beats - b0), 7);
        chk("s6_cyc_cycles", 32'(cyc_cycles), 9);
        chk("s6_frames", frames_sent_o, 5);

        // Largest accepted length with OOB
        cyc_cycles = 0;
        start_frame(1500, 8'hA5, 16'h88B5, 1'b1, 16'hBEEF);
        wait_done(2000);
        chk("max_cyc_cycles", 32'(cyc_cycles), 761);
        chk("max_frames", frames_sent_o, 6);
        chk("max_q_empty", 32'(exp_q.size()), 0);

        // Reset mid-payload, then a clean frame
        b0 = beats;
        start_frame(20, 8'h33, 16'h0800, 1'b0, 16'h0);
        n = 0;
        while (beats < b0 + 10 && n < 100) begin
            tick();
            n++;
        end
        d0 = done_cnt;
        e0 = err_cnt;
        rst_n_i = 1'b0;
        #1;
        chk("mr_cyc", 32'(src_cyc_o), 0);
        chk("mr_stb", 32'(src_stb_o), 0);
        chk("mr_busy", 32'(busy_o), 0);
        chk("mr_dat", 32'(src_dat_o), 0);
        chk("mr_sel", 32'(src_sel_o), 3);
        chk("mr_frames", frames_sent_o, 0);
        repeat (3) tick();
        rst_n_i = 1'b1;
        exp_q.delete();
        repeat (2) tick();
        chk("mr_no_done", 32'(done_cnt), 32'(d0));
        chk("mr_no_err", 32'(err_cnt), 32'(e0));
        start_frame(5, 8'h80, 16'h88F7, 1'b1, 16'h1234);
        wait_done(100);
        chk("mr_frames_after", frames_sent_o, 1);
        chk("mr_q_empty", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
